// File: rtl/pru_pkg.sv
`default_nettype none
// ============================================================================
// pru_pkg : shared beat width, head-beat field positions, TX framing states
// Rev 1.0
// ============================================================================
package pru_pkg;

  localparam int PW = 128;

  localparam int PKT_TYPE_MSB = 127;
  localparam int PKT_TYPE_LSB = 122;
  localparam int PKT_SIZE_MSB = 121;
  localparam int PKT_SIZE_LSB = 114;
  localparam int PKT_SRC_MSB  = 63;
  localparam int PKT_SRC_LSB  = 32;
  localparam int PKT_TRGT_MSB = 31;
  localparam int PKT_TRGT_LSB = 0;

  typedef enum logic [0:0] {
    PRU_TX_HEAD = 1'b0,
    PRU_TX_DATA = 1'b1
  } pru_tx_state_e;

endpackage : pru_pkg
`default_nettype wire

// File: rtl/pru_port_tx_if.sv
`default_nettype none
// ============================================================================
// pru_port_tx_if : core-side and device-side beat handshakes of one TX port
// Rev 1.0
// ============================================================================
interface pru_port_tx_if #(
  parameter int PW = 128
);
  logic          iCore_vld;
  logic [PW-1:0] iCore_pkt;
  logic          oCore_ack;
  logic          oPort_vld;
  logic [PW-1:0] oPort_pkt;
  logic          iPort_ack;

  // slave: the transmitter itself; master: the core/device environment
  modport slave (
    input  iCore_vld, iCore_pkt, iPort_ack,
    output oCore_ack, oPort_vld, oPort_pkt
  );

  modport master (
    output iCore_vld, iCore_pkt, iPort_ack,
    input  oCore_ack, oPort_vld, oPort_pkt
  );
endinterface : pru_port_tx_if
`default_nettype wire

// File: rtl/pru_sync_fifo.sv
`default_nettype none
// ============================================================================
// pru_sync_fifo : single-clock power-of-2 FIFO, no bypass when full
// Rev 1.0
// ============================================================================
module pru_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q + AW'(w_push);
    rptr_d  = rptr_q + AW'(w_pop);
    count_d = count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  // Storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule : pru_sync_fifo
`default_nettype wire

// File: rtl/pru_port_tx.sv
`default_nettype none
// ============================================================================
// pru_port_tx : PRU egress port - beat FIFO, framing, packet count, stall flag
// Rev 1.0
// ============================================================================
module pru_port_tx
  import pru_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 1024
) (
  input  logic            iClk,
  input  logic            iRstn,
  pru_port_tx_if.slave    bus,
  output logic            oSof,
  output logic            oEof,
  output logic [15:0]     oPktCnt,
  output logic            oStall,
  input  logic            iStallClr
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_MAX + 1);

  logic          w_full, w_empty, w_xfer;
  logic [AW:0]   w_count;
  logic [PW-1:0] w_rdata;
  logic [7:0]    w_size;

  pru_tx_state_e state_q;
  logic [7:0]    rem_q;
  logic [15:0]   pktcnt_q;
  logic [SW-1:0] scnt_q;
  logic          stall_q;

  pru_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (iClk),
    .rst_ni  (iRstn),
    .push_i  (bus.oCore_ack),
    .pop_i   (w_xfer),
    .wdata_i (bus.iCore_pkt),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign bus.oCore_ack = bus.iCore_vld && !w_full;
  assign bus.oPort_vld = (w_count != '0);
  assign bus.oPort_pkt = w_empty ? '0 : w_rdata;

  assign w_xfer = bus.oPort_vld && bus.iPort_ack;
  assign w_size = w_rdata[PKT_SIZE_MSB:PKT_SIZE_LSB];

  assign oSof    = bus.oPort_vld && (state_q == PRU_TX_HEAD);
  assign oEof    = bus.oPort_vld && (((state_q == PRU_TX_HEAD) && (w_size == 8'd0)) ||
                                     ((state_q == PRU_TX_DATA) && (rem_q == 8'd1)));
  assign oPktCnt = pktcnt_q;
  assign oStall  = stall_q;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q  <= PRU_TX_HEAD;
      rem_q    <= 8'd0;
      pktcnt_q <= 16'd0;
      scnt_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (w_xfer) begin
        case (state_q)
          PRU_TX_HEAD: begin
            if (w_size == 8'd0) begin
              pktcnt_q <= pktcnt_q + 16'd1;
            end else begin
              rem_q   <= w_size;
              state_q <= PRU_TX_DATA;
            end
          end
          PRU_TX_DATA: begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q  <= PRU_TX_HEAD;
              pktcnt_q <= pktcnt_q + 16'd1;
            end
          end
          default: state_q <= PRU_TX_HEAD;
        endcase
      end

      // Clear beats a coincident set; the flag never gates traffic.
      if (iStallClr) begin
        scnt_q  <= '0;
        stall_q <= 1'b0;
      end else begin
        if (scnt_q == SW'(STALL_MAX)) begin
          stall_q <= 1'b1;
        end
        if (!bus.oPort_vld || w_xfer) begin
          scnt_q <= '0;
        end else if (scnt_q != SW'(STALL_MAX)) begin
          scnt_q <= scnt_q + SW'(1);
        end
      end
    end
  end
endmodule : pru_port_tx
`default_nettype wire

// File: doc/pru_port_tx.md
# pru_port_tx

Egress transmitter for one PRU device port: accepts packet beats from the switch core (output-arbiter side), buffers them in a small FIFO and drives them to the attached device over the port valid/ack handshake. It is the outbound counterpart of the per-port ingress interface and sits between the core's output arbiter and the device pins `oPort_<n>_vld`, `oPort_<n>_pkt` and `iPort_<n>_ack`. It tracks packet framing from the head beat, counts packets sent and flags a device that stops acknowledging.

## Interface
- `PW`, 128: packet beat width; the head-beat field positions below assume 128.
- `DEPTH`, 4: FIFO depth in beats; must be a power of 2 and at least 2.
- `STALL_MAX`, 1024: consecutive unacknowledged valid cycles before the stall flag is raised.

Ports:
- `iClk`  in  1  clock.
- `iRstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `iCore_vld`  in  1  core presents a beat.
- `iCore_pkt`  in  PW  beat from the core.
- `oCore_ack`  out  1  beat accepted this cycle.
- `oPort_vld`  out  1  beat valid toward the device.
- `oPort_pkt`  out  PW  beat toward the device.
- `iPort_ack`  in  1  device accepts the beat.
- `oSof`  out  1  current `oPort_pkt` is a head beat.
- `oEof`  out  1  current `oPort_pkt` is the last beat of its packet.
- `oPktCnt`  out  16  packets fully transmitted; wraps.
- `oStall`  out  1  sticky stall flag.
- `iStallClr`  in  1  clears `oStall` and the stall counter.

## Operation
- **Head beat format:**
  - [127:122] is the type; it is passed through and not checked.
  - [121:114] is SIZE, the number of data beats that follow (0 to 255).
  - [63:32] is the source address.
  - [31:0] is the target address.
- **Core side:**
  - `oCore_ack = iCore_vld && (count < DEPTH)`.
  - A beat is pushed when `oCore_ack` is 1.
  - There is no bypass when full: a pop in the same cycle does not allow a push.
- **Device side:**
  - `oPort_vld = (count != 0)`.
  - `oPort_pkt` is the FIFO head.
  - A transfer happens when `oPort_vld && iPort_ack` are both 1 in the same cycle.
  - `oPort_pkt` must stay stable while `oPort_vld` is 1 and no transfer has occurred.
  - `iPort_ack` while `oPort_vld` is 0 is ignored.
- **Simultaneous push and pop** when not full: count is unchanged and both pointers advance.
- **Framing FSM**, two states, advancing only on a device transfer:
  - HEAD: the FIFO head beat is treated as a head.
    - On transfer with SIZE=0: stay in HEAD and increment `oPktCnt`.
    - On transfer with SIZE>0: load `rem = SIZE` and go to DATA.
  - DATA: on transfer, decrement `rem`.
    - The transfer with `rem == 1` returns the FSM to HEAD and increments `oPktCnt`.
- **Framing outputs:**
  - `oSof = oPort_vld && state==HEAD`.
  - `oEof = oPort_vld && ((state==HEAD && SIZE==0) || (state==DATA && rem==1))`.
- **Counter widths:**
  - `rem` is 8 bits.
  - `oPktCnt` is 16 bits and wraps from 0xFFFF to 0x0000.
- **Stall monitor:**
  - `scnt` increments each cycle with `oPort_vld && !iPort_ack`, saturating at STALL_MAX.
  - `scnt` resets to 0 on any transfer or when `oPort_vld` is 0.
  - `oStall` sets on the cycle after `scnt` reaches STALL_MAX and holds until `iStallClr`.
  - If `iStallClr` and the set condition occur together, clear wins.
  - The stall flag does not block traffic.

## Timing
- **Reset values**, applied immediately on `iRstn` low and asynchronous to the clock:
  - `oCore_ack` follows its combinational equation and is 0 while empty only if `iCore_vld` is 0.
  - `oPort_vld=0`, `oPort_pkt=0`, `oSof=0`, `oEof=0`, `oPktCnt=0`, `oStall=0`.
  - FIFO empty, state HEAD, `rem=0`, `scnt=0`.
- **Latency:** a beat pushed in cycle N into an empty FIFO shows `oPort_vld=1` in cycle N+1.
- **Throughput:** one beat per cycle in steady state.
- **Reset mid-packet:** all buffered beats are discarded and framing restarts at HEAD. The device sees `oPort_vld` drop asynchronously.
- **Full:** `count` reaches DEPTH, and `oCore_ack` stays 0 until the cycle after a pop.
- **Pointers:** log2(DEPTH) bits wide, wrapping naturally. `count` is log2(DEPTH)+1 bits.

## Structure
- Shared package `pru_pkg`:
  - `PW`.
  - Head field constants `PKT_TYPE_MSB/LSB` (127/122), `PKT_SIZE_MSB/LSB` (121/114), `PKT_SRC_MSB/LSB` (63/32), `PKT_TRGT_MSB/LSB` (31/0).
  - FSM state encoding `PRU_TX_HEAD`, `PRU_TX_DATA`.
- Sub-module `pru_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the buffer.
- The FSM, packet counter and stall monitor live in `pru_port_tx`.

## Test plan
- **Single head-only packet:** push a head with SIZE=0 while `iPort_ack`=1 -> `oPort_vld` in the next cycle with `oSof=1` and `oEof=1`; `oPktCnt` reads 1 after the transfer.
- **Packet with SIZE=3:** push head + 3 data beats, hold `iPort_ack`=0 for 5 cycles -> `oPort_pkt` stays stable on the head; FIFO full with `DEPTH=4` drops `oCore_ack` to 0. Release ack -> 4 transfers, `oEof` on the 4th, `oPktCnt`=1.
- **Back-to-back packets with `iPort_ack` toggled every cycle:** send SIZE=1, SIZE=0, SIZE=2 -> `oSof`/`oEof` correct on each beat, beat order preserved, `oPktCnt`=3.
- **Stall:** `STALL_MAX=8`, one beat pending, ack held at 0 -> `oStall` rises after 8 stalled cycles. `iStallClr` clears it; an ack during counting resets `scnt` and no flag is raised.
- **Reset mid-packet:** after the head and 1 of 3 data beats have transferred, pulse `iRstn` low -> all outputs go to reset values. A fresh head with SIZE=0 then transmits with `oSof=1` and `oPktCnt`=1.
- **Wrap:** preload the counter near wrap via 65537 head-only packets (or a forced value 0xFFFF) -> `oPktCnt` goes 0xFFFF -> 0x0000 -> 0x0001.
